// File: rtl/bridge_actuator.sv
// Drawbridge actuator sequencer.
// Turns the controller's level raise command into an ordered motor sequence:
// barrier down, span up, hold open, span down, barrier release.
// A fault latches on a timeout, a car on the span, a sagging span or
// contradictory limit switches, and only reset clears it.
module bridge_actuator #(
  parameter int BARRIER_TIMEOUT = 200,
  parameter int LIFT_TIMEOUT    = 1000,
  parameter int SETTLE          = 16,
  parameter int TW              = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_raise_req,
  input  logic       i_has_car,
  input  logic       i_barrier_down,
  input  logic       i_lim_up,
  input  logic       i_lim_down,
  output logic       o_barrier_motor,
  output logic       o_lift_up,
  output logic       o_lift_down,
  output logic       o_bridge_up,
  output logic       o_busy,
  output logic       o_fault,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    CLOSED   = 3'b000,
    BARRIER  = 3'b001,
    RAISING  = 3'b010,
    OPEN     = 3'b011,
    LOWERING = 3'b100,
    RELEASE  = 3'b101,
    FAULT    = 3'b111
  } state_t;

  // Timer values on the last allowed cycle of each timed state.
  localparam logic [TW-1:0] BARRIER_LAST = TW'(BARRIER_TIMEOUT - 1);
  localparam logic [TW-1:0] LIFT_LAST    = TW'(LIFT_TIMEOUT - 1);
  localparam logic [TW-1:0] SETTLE_LAST  = TW'(SETTLE - 1);

  state_t        r_state;
  state_t        w_next;
  logic [TW-1:0] r_timer;
  logic          w_conflict;

  // Both limit switches closed at once means a broken sensor or wiring.
  assign w_conflict = i_lim_up & i_lim_down;

  // State register and per-state cycle timer (cleared on every state change,
  // saturating so a long-lived state never wraps back into a timeout match).
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      r_state <= CLOSED;
      r_timer <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_timer <= '0;
      end else if (r_timer != '1) begin
        r_timer <= r_timer + 1'b1;
      end
    end
  end

  // Next-state logic; completion sensors are tested before timeouts.
  always_comb begin
    // NOTE: default assigned first so every path drives w_next and no latch
    // is inferred.
    w_next = r_state;
    unique case (r_state)
      CLOSED: begin
        if (i_raise_req && !i_has_car) w_next = BARRIER;
      end
      BARRIER: begin
        if (i_barrier_down)                w_next = RAISING;
        else if (!i_raise_req)             w_next = RELEASE;
        else if (r_timer == BARRIER_LAST)  w_next = FAULT;
      end
      RAISING: begin
        if (i_has_car || !i_barrier_down)  w_next = FAULT;
        else if (i_lim_up)                 w_next = OPEN;
        else if (r_timer == LIFT_LAST)     w_next = FAULT;
      end
      OPEN: begin
        if (!i_raise_req)                  w_next = LOWERING;
        else if (!i_lim_up)                w_next = FAULT;
      end
      LOWERING: begin
        if (i_lim_down)                    w_next = RELEASE;
        else if (r_timer == LIFT_LAST)     w_next = FAULT;
      end
      RELEASE: begin
        if (r_timer == SETTLE_LAST)        w_next = CLOSED;
      end
      FAULT: begin
        w_next = FAULT;
      end
      default: begin
        w_next = FAULT;
      end
    endcase
    if (w_conflict && r_state != FAULT) w_next = FAULT;
  end

  // Moore output decode from the registered state only.
  always_comb begin
    o_barrier_motor = 1'b0;
    o_lift_up       = 1'b0;
    o_lift_down     = 1'b0;
    o_bridge_up     = 1'b0;
    o_busy          = 1'b0;
    o_fault         = 1'b0;
    unique case (r_state)
      CLOSED:   ;
      BARRIER:  begin o_barrier_motor = 1'b1; o_busy = 1'b1; end
      RAISING:  begin o_barrier_motor = 1'b1; o_lift_up = 1'b1; o_busy = 1'b1; end
      OPEN:     begin o_barrier_motor = 1'b1; o_bridge_up = 1'b1; end
      LOWERING: begin o_barrier_motor = 1'b1; o_lift_down = 1'b1; o_busy = 1'b1; end
      RELEASE:  begin o_busy = 1'b1; end
      FAULT:    begin o_barrier_motor = 1'b1; o_fault = 1'b1; end
      default:  begin o_barrier_motor = 1'b1; o_fault = 1'b1; end
    endcase
  end

  assign o_state = r_state;

endmodule

// File: doc/bridge_actuator.md
Name: bridge_actuator

Overview:
Actuator sequencer that takes the drawbridge controller's level commands and executes them against the physical mechanism.
- Drives the car-barrier motor and the span lift motor.
- Enforces barrier-before-lift and lower-before-release ordering.
- Watches the limit switches and timeouts, and reports status (bridge up, busy, fault) back to the controller.
- Sits between the drawbridge controller outputs and the motor drivers and sensors.

Parameters:
BARRIER_TIMEOUT, 200, max cycles allowed for the barrier-down sensor after the barrier motor starts
LIFT_TIMEOUT, 1000, max cycles allowed for the i_lim_up / i_lim_down limit switch during a lift or lower
SETTLE, 16, cycles the barrier is held released before returning to CLOSED
TW, 16, timer width; must hold max(BARRIER_TIMEOUT, LIFT_TIMEOUT, SETTLE)

Ports:
i_clk  input  1  clock
i_reset  input  1  reset, synchronous, active-low; clock i_clk
i_raise_req  input  1  level command from the controller: 1 = bridge should be raised
i_has_car  input  1  car-on-span flag from the car counter (safety interlock)
i_barrier_down  input  1  barrier fully-down sensor
i_lim_up  input  1  span fully-raised limit switch
i_lim_down  input  1  span fully-lowered limit switch
o_barrier_motor  output  1  1 = drive/hold barrier down
o_lift_up  output  1  lift motor, raise direction
o_lift_down  output  1  lift motor, lower direction
o_bridge_up  output  1  span raised and stable
o_busy  output  1  sequence in progress (any state except CLOSED, OPEN, FAULT)
o_fault  output  1  latched fault
o_state  output  3  current state encoding (debug)

Behaviour:
General rules
- Moore FSM. Outputs are decoded from the registered state only and valid in the same cycle as the state.
- o_lift_up and o_lift_down are never both 1.
- Reset (i_reset=0 at a posedge) forces CLOSED and clears the timer, regardless of the current state, FAULT included. In CLOSED, all outputs are 0 and o_state=000.
- Timer: TW-bit, cleared on every state change, increments each cycle within a state, saturates at all-ones.
- Where both are possible in the same cycle, the completion sensor has priority over the timeout.

States and transitions
- CLOSED(000), all outputs 0:
  - i_raise_req=1 and i_has_car=0 -> BARRIER.
  - i_raise_req=1 with i_has_car=1 -> stay (wait for the span to clear).
- BARRIER(001), o_barrier_motor=1, o_busy=1:
  - i_barrier_down=1 -> RAISING.
  - Else, if i_raise_req=0 -> RELEASE (request withdrawn).
  - Else, timer==BARRIER_TIMEOUT-1 -> FAULT.
- RAISING(010), o_barrier_motor=1, o_lift_up=1, o_busy=1:
  - i_has_car=1 or i_barrier_down=0 -> FAULT; this takes priority.
  - Else, i_lim_up=1 -> OPEN.
  - Else, timer==LIFT_TIMEOUT-1 -> FAULT.
  - i_raise_req dropping is ignored; the lift always completes.
- OPEN(011), o_barrier_motor=1, o_bridge_up=1:
  - i_raise_req=0 -> LOWERING.
  - i_lim_up=0 while OPEN -> FAULT (span sagging).
- LOWERING(100), o_barrier_motor=1, o_lift_down=1, o_busy=1:
  - i_lim_down=1 -> RELEASE.
  - Else, timer==LIFT_TIMEOUT-1 -> FAULT.
  - i_raise_req re-asserting is ignored; the span must fully lower before a new cycle.
- RELEASE(101), o_busy=1, barrier motor off:
  - timer==SETTLE-1 -> CLOSED.
  - A new i_raise_req is not accepted until CLOSED.
- FAULT(111), o_fault=1, o_barrier_motor=1 (barrier held down for safety), lift motors 0:
  - Exit only via reset.
- From any non-FAULT state, i_lim_up=1 and i_lim_down=1 together -> FAULT. This takes priority over all other transitions.

Latency
- From i_raise_req rising (sampled at edge N) to o_barrier_motor=1: 1 cycle.
- From i_lim_up to o_bridge_up: 1 cycle.
- A full cycle with ideal sensors is 1 + barrier time + lift time + 1 + lower time + SETTLE cycles.

Test Plan:
Parameters for the bench: BARRIER_TIMEOUT=8, LIFT_TIMEOUT=20, SETTLE=4.
1. Normal cycle: raise_req=1, has_car=0; barrier_down at +3; lim_up at +10; drop raise_req; lim_down at +10 -> states 001,010,011,100,101,000. o_bridge_up=1 only in OPEN. CLOSED re-entered exactly 4 cycles after RELEASE entry.
2. Car interlock: raise_req=1 with has_car=1 for 5 cycles, then has_car=0 -> stays 000 with all outputs 0 for 5 cycles, then 001 one cycle later.
3. Barrier timeout: raise_req=1, barrier_down held 0 -> FAULT after exactly 8 cycles in BARRIER; o_fault=1, o_barrier_motor=1, o_lift_up=0. FAULT persists until i_reset=0 for one edge, then 000.
4. Withdrawal and car-during-lift: drop raise_req in BARRIER -> RELEASE -> CLOSED after 4 cycles. Separately, has_car=1 during RAISING -> FAULT next edge, o_lift_up=0.
5. Lift timeout and sensor conflict: lim_up never asserted -> FAULT after 20 RAISING cycles. lim_up=lim_down=1 in OPEN -> FAULT next edge.
6. Reset mid-operation: i_reset=0 during LOWERING -> next edge 000, all outputs 0, timer 0. Completion sensor asserted on the same cycle as the timeout -> normal transition, no FAULT.
